pcie_tx_arbiter: RTL and testbench
==================================

# pcie_tx_arbiter

Round-robin arbiter that shares the single PCIe TX AXI4-S channel toward the HIP TX bridge among NUM_REQ TLP requesters, such as the MMIO completion path and the DMA engines. The arbiter locks a grant for the full length of a TLP, from SOP to EOP, so beats from different requesters never interleave. It then registers the selected beat into a one-deep output stage using the same load rule as the RX bridge. The block sits between the FIM TX requesters and the PCIe TX bridge, in the avl_clk domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 512, TLP beat width (hdr+payload, both AVST channels)
- USER_W, 16, per-beat sideband (vf_active/pfn/vfn etc.), passed through
- avl_clk  in  1  clock; all I/O synchronous to it
- avl_rst_n  in  1  reset, asynchronous, active-low
- req_tvalid  in  NUM_REQ  per-requester beat valid
- req_tready  out  NUM_REQ  per-requester beat accept
- req_sop  in  NUM_REQ  beat is first of TLP
- req_eop  in  NUM_REQ  beat is last of TLP
- req_tdata  in  NUM_REQ*DATA_W  beat data, requester i at [i*DATA_W +: DATA_W]
- req_tuser  in  NUM_REQ*USER_W  sideband, same packing
- req_en  in  NUM_REQ  arbitration enable mask (quasi-static config)
- out_tvalid  out  1  registered output valid
- out_tready  in  1  downstream accept
- out_sop, out_eop  out  1 each  registered flags
- out_tdata  out  DATA_W  registered data
- out_tuser  out  USER_W  registered sideband
- out_src  out  $clog2(NUM_REQ)  index of requester that produced the beat
- proto_err  out  1  sticky: non-SOP beat offered while unlocked

## Operation
- ld = ~out_tvalid | out_tready. No requester is accepted when ld=0.
- State machine states:
  - IDLE: no grant held.
  - LOCK: grant held by gnt, mid-TLP.
- IDLE:
  - Candidates are i with req_tvalid[i] & req_en[i].
  - Pick the first candidate scanning from ptr upward, wrapping modulo NUM_REQ, and assert req_tready[sel]=ld.
  - On accept:
    - sop & eop: single-beat TLP; ptr <= sel+1 (wrap); stay IDLE.
    - sop & ~eop: gnt <= sel; go to LOCK.
    - ~sop: beat dropped (not loaded into the output); proto_err <= 1; ptr <= sel+1; stay IDLE.
- LOCK:
  - req_tready[gnt]=ld; all other req_tready are 0.
  - req_en and other requests are ignored.
  - On an accepted beat with eop: ptr <= gnt+1 (wrap); go to IDLE.
  - An sop on a mid-TLP beat is passed through as-is. It is not checked.
- Output stage: on an accepted, non-dropped beat, load data/user/sop/eop, out_src <= index, out_tvalid <= 1. If ld & no load, out_tvalid <= 0.
- ptr changes only at TLP completion or drop. A requester gaps (tvalid=0) mid-TLP keep LOCK indefinitely; no timeout.
- proto_err clears only on reset.

## Timing
- Reset (async assert, sync release):
  - out_tvalid=0, out_sop=0, out_eop=0, out_src=0, proto_err=0, state=IDLE, ptr=0, gnt=0.
  - out_tdata/out_tuser are not reset.
  - req_tready=0 during reset.
- req_tready is combinational from req_tvalid/req_en/state/ptr/out_tvalid/out_tready. No combinational path from req_tdata.
- Latency: beat accepted in cycle N appears on out_* in N+1.
- Throughput: one beat/cycle sustained, including back-to-back TLPs from different requesters (IDLE arbitration costs no cycle).
- Output holds all fields stable while out_tvalid & ~out_tready.
- Reset mid-TLP: lock and output are discarded. The first post-reset beat must be SOP, else proto_err.

## Test plan
- Req0 alone sends a 3-beat TLP (sop/-/eop), out_tready=1 -> out beats in cycles N+1..N+3, out_src=0, ptr=1 after; req_tready0 high each cycle.
- Req0 and req2 both hold 2-beat TLPs continuously, ptr=0 -> output order req0,req0,req2,req2,req0,... with no idle cycles and no interleave.
- Req1 locked after SOP; req3 valid; out_tready low 2 cycles mid-TLP -> out_* stable, req_tready all 0, req3 waits until req1 EOP accepted.
- req_en=4'b1011, all valid single-beat TLPs, ptr=2 -> grants 3,0,1,3,...; req2 never readied.
- Req1 offers sop=0 beat while IDLE -> accepted, not output, proto_err=1 from next cycle, ptr=2; stays set until reset.
- Assert avl_rst_n=0 mid-TLP of req0 while out_tvalid=1 -> out_tvalid=0 immediately (async); after release, req1 SOP beat granted, ptr=0 scan.

Source files
------------

// File: rtl/pcie_tx_arbiter.sv
// Round-robin arbiter onto the shared PCIe TX AXI4-S channel.
// A grant is held from SOP to EOP, and the chosen beat is registered into a one-deep output stage.
module pcie_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned USER_W  = 16,
    localparam int unsigned SrcW   = $clog2(NUM_REQ)
) (
    input  logic                      avl_clk,
    input  logic                      avl_rst_n,
    input  logic [NUM_REQ-1:0]        req_tvalid,
    output logic [NUM_REQ-1:0]        req_tready,
    input  logic [NUM_REQ-1:0]        req_sop,
    input  logic [NUM_REQ-1:0]        req_eop,
    input  logic [NUM_REQ*DATA_W-1:0] req_tdata,
    input  logic [NUM_REQ*USER_W-1:0] req_tuser,
    input  logic [NUM_REQ-1:0]        req_en,
    output logic                      out_tvalid,
    input  logic                      out_tready,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [DATA_W-1:0]         out_tdata,
    output logic [USER_W-1:0]         out_tuser,
    output logic [SrcW-1:0]           out_src,
    output logic                      proto_err
);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e            state_q, state_d;
    logic [SrcW-1:0]   ptr_q, ptr_d;
    logic [SrcW-1:0]   gnt_q, gnt_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [SrcW-1:0]    sel;
    logic [SrcW-1:0]    cur;
    int unsigned        scan_idx;
    logic               ld;
    logic               accept;
    logic               drop;
    logic               load;

    function automatic logic [SrcW-1:0] wrap_inc(input logic [SrcW-1:0] x);
        if (32'(x) == NUM_REQ - 1) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    assign ld   = ~out_tvalid | out_tready;
    assign cand = req_tvalid & req_en;

    // First enabled requester at or after ptr, wrapping around.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(ptr_q) + 32'(k)) % NUM_REQ;
            if (!found && cand[scan_idx[SrcW-1:0]]) begin
                found = 1'b1;
                sel   = scan_idx[SrcW-1:0];
            end
        end
    end

    assign cur    = (state_q == StLock) ? gnt_q : sel;
    assign accept = |(req_tready & req_tvalid);
    assign drop   = accept & (state_q == StIdle) & ~req_sop[cur];
    assign load   = accept & ~drop;

    always_ff @(posedge avl_clk or negedge avl_rst_n) begin
        if (!avl_rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!req_sop[cur]) begin
                        err_d = 1'b1;
                        ptr_d = wrap_inc(cur);
                    end else if (req_eop[cur]) begin
                        ptr_d = wrap_inc(cur);
                    end else begin
                        gnt_d   = cur;
                        state_d = StLock;
                    end
                end
            end
            StLock: begin
                if (accept && req_eop[cur]) begin
                    ptr_d   = wrap_inc(cur);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Ready is held low while reset is asserted, even though the FSM already reads idle.
    always_comb begin
        req_tready = '0;
        if (avl_rst_n) begin
            if (state_q == StLock) begin
                req_tready[gnt_q] = ld;
            end else if (found) begin
                req_tready[sel] = ld;
            end
        end
    end

    assign proto_err = err_q;

    always_ff @(posedge avl_clk or negedge avl_rst_n) begin
        if (!avl_rst_n) begin
            out_tvalid <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_src    <= '0;
        end else if (load) begin
            out_tvalid <= 1'b1;
            out_sop    <= req_sop[cur];
            out_eop    <= req_eop[cur];
            out_src    <= cur;
        end else if (ld) begin
            out_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge avl_clk) begin
        if (load) begin
            out_tdata <= req_tdata[cur*DATA_W +: DATA_W];
            out_tuser <= req_tuser[cur*USER_W +: USER_W];
        end
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: directed vector table, hand sequences, then random traffic
// checked against a packet-level reference model.
module tb_pcie_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int SW = $clog2(N);

    logic            avl_clk = 1'b0;
    logic            avl_rst_n = 1'b0;
    logic [N-1:0]    req_tvalid = '0, req_tready, req_sop = '0, req_eop = '0, req_en = '1;
    logic [N*DW-1:0] req_tdata = '0;
    logic [N*UW-1:0] req_tuser = '0;
    logic            out_tvalid, out_tready = 1'b1, out_sop, out_eop, proto_err;
    logic [DW-1:0]   out_tdata;
    logic [UW-1:0]   out_tuser;
    logic [SW-1:0]   out_src;

    always #5 avl_clk = ~avl_clk;

    pcie_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .USER_W(UW)) dut (
        .avl_clk    (avl_clk),
        .avl_rst_n  (avl_rst_n),
        .req_tvalid (req_tvalid),
        .req_tready (req_tready),
        .req_sop    (req_sop),
        .req_eop    (req_eop),
        .req_tdata  (req_tdata),
        .req_tuser  (req_tuser),
        .req_en     (req_en),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_tdata  (out_tdata),
        .out_tuser  (out_tuser),
        .out_src    (out_src),
        .proto_err  (proto_err)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit bitat(input logic [N-1:0] v, input int i);
        return v[i[SW-1:0]];
    endfunction

    // Reference model: owner = -1 when no TLP is in progress.
    int             m_ptr, m_owner, m_src;
    bit             m_err, m_vld, m_sop, m_eop;
    logic [DW-1:0]  m_data;
    logic [UW-1:0]  m_user;

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_src = 0;
        m_err = 0; m_vld = 0; m_sop = 0; m_eop = 0;
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic cycle();
        bit ld, acc, loaded, sop, eop;
        int who;
        logic [N-1:0] er;
        #1;
        ld  = !m_vld || out_tready;
        who = -1;
        if (m_owner >= 0) who = m_owner;
        else begin
            for (int k = 0; k < N; k++)
                if (who < 0 && bitat(req_tvalid, (m_ptr + k) % N) && bitat(req_en, (m_ptr + k) % N))
                    who = (m_ptr + k) % N;
        end
        er = '0;
        if (who >= 0 && ld) er = N'(1) << who;
        chk("req_tready", 64'(req_tready), 64'(er));
        @(posedge avl_clk);
        acc    = who >= 0 && ld && bitat(req_tvalid, who);
        loaded = 0;
        if (acc) begin
            sop = bitat(req_sop, who);
            eop = bitat(req_eop, who);
            if (m_owner < 0 && !sop) begin
                m_err = 1;
                m_ptr = (who + 1) % N;
            end else begin
                loaded = 1;
                m_vld  = 1; m_sop = sop; m_eop = eop; m_src = who;
                m_data = DW'(req_tdata >> (who * DW));
                m_user = UW'(req_tuser >> (who * UW));
                if (m_owner < 0) begin
                    if (eop) m_ptr = (who + 1) % N;
                    else m_owner = who;
                end else if (eop) begin
                    m_owner = -1;
                    m_ptr   = (who + 1) % N;
                end
            end
        end
        if (!loaded && ld) m_vld = 0;
        #1;
        chk("out_tvalid", 64'(out_tvalid), 64'(m_vld));
        chk("proto_err", 64'(proto_err), 64'(m_err));
        if (m_vld) begin
            chk("out_src", 64'(out_src), 64'(m_src));
            chk("out_sop", 64'(out_sop), 64'(m_sop));
            chk("out_eop", 64'(out_eop), 64'(m_eop));
            chk("out_tdata", 64'(out_tdata), 64'(m_data));
            chk("out_tuser", 64'(out_tuser), 64'(m_user));
        end
    endtask

    task automatic clear_inputs();
        req_tvalid = '0; req_sop = '0; req_eop = '0; req_en = '1; out_tready = 1'b1;
    endtask

    task automatic reset_dut();
        avl_rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge avl_clk);
        @(negedge avl_clk);
        avl_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_data();
        req_tdata = {$urandom, $urandom, $urandom, $urandom};
        req_tuser = $urandom;
    endtask

    typedef struct {
        logic [N-1:0] tv, sop, eop, en;
        logic         ot;
        logic [N-1:0] rdy;
        logic         vld, osop, oeop, err;
        int           src, row;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [N-1:0]    b;
        logic [N-1:0]    acc_v;
        logic [DW-1:0]   held;
        logic [N*DW-1:0] dv;

        // Ready must stay low while reset is asserted.
        req_tvalid = '1; req_sop = '1; req_en = '1;
        #2;
        chk("rst_tready", 64'(req_tready), 64'(0));
        reset_dut();
        chk("rst_out_tvalid", 64'(out_tvalid), 64'(0));
        chk("rst_out_sop", 64'(out_sop), 64'(0));
        chk("rst_out_eop", 64'(out_eop), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_proto_err", 64'(proto_err), 64'(0));

        // 3-beat TLP from req0, dropped non-SOP beat from req1, masked round robin, backpressure.
        tbl[0] = '{4'b0001, 4'b0001, 4'b0000, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{4'b0001, 4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
        tbl[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2};
        tbl[3] = '{4'b0010, 4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2};
        tbl[4] = '{4'b1111, 4'b1111, 4'b1111, 4'b1011, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 3, 4};
        tbl[5] = '{4'b1111, 4'b1111, 4'b1111, 4'b1011, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 0, 5};
        tbl[6] = '{4'b1111, 4'b1111, 4'b1111, 4'b1011, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1, 6};
        tbl[7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1011, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 3, 7};
        tbl[8] = '{4'b1111, 4'b1111, 4'b1111, 4'b1011, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 3, 7};
        tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 0, 7};
        for (int r = 0; r < 10; r++) begin
            req_tvalid = tbl[r].tv; req_sop = tbl[r].sop; req_eop = tbl[r].eop;
            req_en = tbl[r].en; out_tready = tbl[r].ot;
            dv = '0;
            for (int i = 0; i < N; i++) dv = dv | ((N*DW)'({8'(i), 24'(r)}) << (i * DW));
            req_tdata = dv;
            #1;
            chk("tbl_tready", 64'(req_tready), 64'(tbl[r].rdy));
            @(posedge avl_clk);
            #1;
            chk("tbl_out_tvalid", 64'(out_tvalid), 64'(tbl[r].vld));
            chk("tbl_proto_err", 64'(proto_err), 64'(tbl[r].err));
            if (tbl[r].vld) begin
                chk("tbl_out_src", 64'(out_src), 64'(tbl[r].src));
                chk("tbl_out_sop", 64'(out_sop), 64'(tbl[r].osop));
                chk("tbl_out_eop", 64'(out_eop), 64'(tbl[r].oeop));
                chk("tbl_out_tdata", 64'(out_tdata), 64'({8'(tbl[r].src), 24'(tbl[r].row)}));
            end
        end

        // req0 and req2 stream 2-beat TLPs back to back.
        reset_dut();
        b = '0;
        req_tvalid = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            req_sop = ~b; req_eop = b;
            rand_data();
            acc_v = 4'b0000;
            #1;
            acc_v = req_tready & req_tvalid;
            cycle();
            b = b ^ acc_v;
            chk("rr_order_valid", 64'(out_tvalid), 64'(1));
            chk("rr_order_src", 64'(out_src), 64'(((c / 2) % 2) * 2));
        end

        // req1 locked, downstream stalls mid-TLP, req3 waits for req1 EOP.
        reset_dut();
        rand_data();
        req_tvalid = 4'b0010; req_sop = 4'b0010; req_eop = 4'b0000;
        cycle();
        held = out_tdata;
        req_tvalid = 4'b1010; req_sop = 4'b1000; out_tready = 1'b0;
        rand_data();
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("stall_tready", 64'(req_tready), 64'(0));
            chk("stall_src", 64'(out_src), 64'(1));
            chk("stall_sop", 64'(out_sop), 64'(1));
            chk("stall_tdata", 64'(out_tdata), 64'(held));
        end
        out_tready = 1'b1;
        cycle();
        chk("lock_mid_src", 64'(out_src), 64'(1));
        req_eop = 4'b0010;
        rand_data();
        cycle();
        chk("lock_eop_src", 64'(out_src), 64'(1));
        req_tvalid = 4'b1000; req_eop = 4'b1000;
        cycle();
        chk("after_lock_src", 64'(out_src), 64'(3));

        // Asynchronous reset in the middle of a req0 TLP.
        reset_dut();
        req_tvalid = 4'b0001; req_sop = 4'b0001; req_eop = 4'b0000;
        rand_data();
        cycle();
        #2;
        avl_rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", 64'(out_tvalid), 64'(0));
        chk("async_rst_tready", 64'(req_tready), 64'(0));
        repeat (2) @(negedge avl_clk);
        avl_rst_n = 1'b1;
        model_reset();
        req_tvalid = 4'b0010; req_sop = 4'b0010; req_eop = 4'b0010;
        cycle();
        chk("post_rst_src", 64'(out_src), 64'(1));
        chk("post_rst_err", 64'(proto_err), 64'(0));

        // Random traffic against the model.
        for (int blk = 0; blk < 3; blk++) begin
            reset_dut();
            for (int c = 0; c < 1000; c++) begin
                req_tvalid = 4'($urandom) | 4'($urandom);
                req_sop    = 4'($urandom) | 4'($urandom);
                req_eop    = 4'($urandom);
                out_tready = ($urandom % 4) != 0;
                if (c % 50 == 0) req_en = 4'($urandom) | 4'($urandom);
                rand_data();
                cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
